ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage. Keeps the program counter and issues single-outstanding word reads to instruction memory. Returned words go into a 2-entry prefetch buffer, and the head of that buffer is presented as `inst` to the decode stage under the same `stall` that freezes decode. Branch/jump redirects from later stages flush the buffer and discard any in-flight response.

## Interface
Parameters:
- `W`, `WORD_WIDTH` (32), data/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `stall`  input  1  decode not accepting; head instruction held
- `redirect`  input  1  control-flow change this cycle
- `redirect_addr`  input  W  new fetch PC
- `imem_req`  output  1  read request, sampled by memory on the rising edge
- `imem_addr`  output  W  request address, word aligned
- `imem_rvalid`  input  1  read data valid; earliest one cycle after the accepted `imem_req`
- `imem_rdata`  input  W  instruction word
- `inst`  output  W  head instruction; `ZERO_WORD` (NOP) when empty
- `inst_pc`  output  W  PC of `inst`; 0 when empty
- `inst_valid`  output  1  buffer non-empty
- `addr_err`  output  1  sticky misaligned-redirect flag (only when the Configuration macro is defined; tied 0 otherwise)

## Operation
- State: `pc` (next fetch address), FIFO `count` 0..2 holding {pc, inst} entries, FSM `IDLE`/`WAIT`/`DROP`.
- `room` = `count` − `pop` + (pending response ? 1 : 0) < 2, evaluated combinationally.
- `pop` = `inst_valid` & !`stall` & !`redirect`.
- `imem_req` = !`redirect` & `room` & (`IDLE`, or `WAIT` & `imem_rvalid`). Back-to-back issue is allowed.
- `imem_addr` = `pc`.
- On issue: `pc` ← `pc`+4, with 32-bit wrap (32'hFFFF_FFFC → 0).
- FSM transitions:
  - `IDLE` → `WAIT` on issue.
  - `WAIT` + `imem_rvalid`: push {issued pc, `imem_rdata`}. Stay in `WAIT` if a new request issues; otherwise go to `IDLE`.
  - `WAIT` + `redirect` without `rvalid` → `DROP`.
  - `WAIT` + `redirect` with `rvalid` → `IDLE`, data discarded.
  - `DROP` + `imem_rvalid` → `IDLE`, data discarded; `imem_req` is held low while in `DROP`.
  - `imem_rvalid` in `IDLE` is ignored (covers stray responses after reset).
- `redirect` has priority over `stall`, `pop`, and push. At the edge: FIFO cleared, `pc` ← `redirect_addr`. A push and a pop in the same cycle leave `count` unchanged.
- Outputs `inst`, `inst_pc`, and `inst_valid` are combinational from the FIFO head.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, `count` = 0, FSM = `IDLE`
  - `imem_req` = 0 while `rst` is low
  - `inst` = 0, `inst_pc` = 0, `inst_valid` = 0, `addr_err` = 0
- First `imem_req` is in the first cycle after `rst` deasserts, with `imem_addr` = `RESET_PC`.
- Latency: with memory latency L, a word is at `inst` L cycles after its request edge. Steady state with L=1 and no stall gives one instruction per cycle.
- Full buffer (`count` = 2, no pop) suppresses `imem_req`.
- Redirect-to-fetch:
  - `imem_req` at `redirect_addr` in the cycle after `redirect` if `IDLE`.
  - If `DROP`, the first request issues in the cycle after the stale response arrives.
- `inst_valid` is 0 in the cycle after `redirect`.
- Reset mid-operation: all state cleared immediately; an outstanding response arriving later is ignored.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A `redirect_addr` with nonzero [1:0] sets sticky `addr_err`, cleared only by reset.
  - Fetching halts: no `imem_req`, `inst_valid` = 0, until reset.
- Undefined:
  - `redirect_addr`[1:0] forced to 0; `addr_err` tied 0.

## Test plan
- Reset release, L=1, `imem_rdata` = addr^32'hA5A5_0000, no stall → requests at 0x0, 0x4, 0x8 on consecutive cycles; `inst_pc` 0x0, 0x4, 0x8 each for one cycle with matching `inst`.
- Hold `stall` = 1 for 5 cycles → `inst`/`inst_pc` stable, exactly two entries buffered, `imem_req` low after the buffer fills; release → in-order delivery with no duplicates.
- L=3, `redirect` = 1 to 0x100 during `WAIT` → stale word never appears; next request at 0x100 in the cycle after the stale `rvalid`; first `inst_pc` = 0x100.
- `redirect` in the same cycle as `imem_rvalid` and `stall` → data dropped, `inst_valid` = 0 next cycle, `imem_req` at `redirect_addr`.
- `redirect_addr` = 32'hFFFF_FFF8 → fetches at FFFF_FFF8, FFFF_FFFC, then 0x0 (wrap).
- `IFETCH_ALIGN_CHECK_EN` defined, `redirect_addr` = 0x102 → `addr_err` = 1 next cycle, no further `imem_req`; undefined → fetch at 0x100.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage.
// Holds the fetch PC and issues single-outstanding word reads to instruction
// memory. Returned words enter a 2-entry prefetch FIFO whose head is
// presented to decode. A redirect flushes the FIFO and discards any in-flight
// response.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect_addr sets sticky addr_err and halts fetch
//               until reset.
//   undefined : redirect_addr[1:0] is ignored (forced to 0), addr_err tied 0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   stall                     decode not accepting; head instruction held
//   redirect, redirect_addr   control-flow change and new fetch PC
//   imem_req, imem_addr       read request / word-aligned address (comb.)
//   imem_rvalid, imem_rdata   read response
//   inst, inst_pc, inst_valid FIFO head presented to decode (comb.)
//   addr_err                  sticky misaligned-redirect flag
module ifetch_unit #(
  parameter int unsigned   WORD_WIDTH = 32,
  parameter int unsigned   W          = WORD_WIDTH,
  parameter logic [W-1:0]  RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [W-1:0] redirect_addr,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] inst,
  output logic [W-1:0] inst_pc,
  output logic         inst_valid,
  output logic         addr_err
);

  localparam logic [W-1:0] ZERO_WORD = '0;
  localparam int unsigned  CNT_W     = 2;
  localparam int unsigned  OCC_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] inst;
  } entry_t;

  state_e           state_q, state_d;
  logic [W-1:0]     pc_q, pc_d;
  logic [W-1:0]     req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           ent0_q, ent0_d;
  entry_t           ent1_q, ent1_d;

  logic             halt;
  logic             pending;
  logic             pop;
  logic             push;
  logic             room;
  logic             issue;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] push_slot;
  logic [W-1:0]     redir_pc;
  entry_t           new_ent;

  // Redirect target is always word aligned on the fetch side.
  assign redir_pc = {redirect_addr[W-1:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;

  // Sticky misalignment flag; only reset clears it.
  always_comb begin
    addr_err_d = addr_err_q;
    if (redirect && (redirect_addr[1:0] != 2'b00)) addr_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= addr_err_d;
  end

  assign halt     = addr_err_q;
  assign addr_err = addr_err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^redirect_addr[1:0];
  assign halt            = 1'b0;
  assign addr_err        = 1'b0;
`endif

  // Head of FIFO presented to decode; NOP when empty or halted.
  assign inst_valid = (count_q != '0) && !halt;
  assign inst       = inst_valid ? ent0_q.inst : ZERO_WORD;
  assign inst_pc    = inst_valid ? ent0_q.pc   : ZERO_WORD;

  assign pending = (state_q == WAIT);
  assign pop     = inst_valid && !stall && !redirect;
  assign push    = pending && imem_rvalid && !redirect;

  // Slots committed after this edge, counting the response still owed.
  assign occ  = OCC_W'(count_q) + OCC_W'(pending) - OCC_W'(pop);
  assign room = (occ < OCC_W'(2));

  // rst gating keeps the request low during reset even though state is IDLE.
  assign issue = rst && !redirect && !halt && room &&
                 ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign push_slot = count_q - CNT_W'(pop);
  assign new_ent   = '{pc: req_pc_q, inst: imem_rdata};

  // Next-state: PC, FIFO and FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;

    if (redirect) begin
      count_d = '0;
      pc_d    = redir_pc;
    end else begin
      if (issue) begin
        pc_d     = pc_q + W'(4);
        req_pc_d = pc_q;
      end
      if (pop) ent0_d = ent1_q;
      // Slot index accounts for a same-cycle pop shifting the tail forward.
      if (push) begin
        if (push_slot == '0) ent0_d = new_ent;
        else                 ent1_d = new_ent;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    unique case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)   state_d = issue ? WAIT : IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      ent0_q   <= '0;
      ent1_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural single-outstanding
// instruction memory of programmable latency. Returned word = addr ^ A5A5_0000.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        addr_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int          lat    = 1;
  logic        m_busy = 1'b0;
  int          m_rem  = 0;
  logic [31:0] m_addr = '0;

  ifetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample request mid-cycle, then advance the memory model.
  task automatic tick();
    logic        s_req;
    logic        s_rv;
    logic [31:0] s_addr;
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    s_rv   = imem_rvalid;
    @(posedge clk);
    #1;
    if (s_rv)        m_busy = 1'b0;
    else if (m_busy) m_rem  = m_rem - 1;
    if (s_req) begin
      m_busy = 1'b1;
      m_rem  = lat;
      m_addr = s_addr;
    end
    imem_rvalid = m_busy && (m_rem == 1);
    imem_rdata  = imem_rvalid ? (m_addr ^ 32'hA5A5_0000) : 32'h0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req),   32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_err",   32'(addr_err),   32'h0);
    tick(); tick();

    // Reset release, L=1 streaming
    rst = 1'b1; #1;
    chk("c0_req",  32'(imem_req), 32'h1);
    chk("c0_addr", imem_addr,     32'h0);
    tick(); #1;
    chk("c1_req",   32'(imem_req),   32'h1);
    chk("c1_addr",  imem_addr,       32'h4);
    chk("c1_valid", 32'(inst_valid), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("str_valid", 32'(inst_valid), 32'h1);
      chk("str_pc",    inst_pc,         32'(4 * i));
      chk("str_inst",  inst,            32'(4 * i) ^ 32'hA5A5_0000);
      chk("str_addr",  imem_addr,       32'(8 + 4 * i));
      tick();
    end

    // Stall for 5 cycles: head held, buffer fills, requests stop
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stl_req",  32'(imem_req), 32'h0);
      chk("stl_pc",   inst_pc,       32'hC);
      chk("stl_inst", inst,          32'hA5A5_000C);
      tick();
    end
    stall = 1'b0; #1;
    chk("rel_pc",   inst_pc,       32'hC);
    chk("rel_req",  32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr,     32'h14);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rel_seq", inst_pc, 32'(32'h10 + 4 * k));
      if (k < 2) tick();
    end

    // Reset mid-operation clears everything immediately
    rst = 1'b0; #1;
    chk("mrst_req",   32'(imem_req),   32'h0);
    chk("mrst_valid", 32'(inst_valid), 32'h0);
    chk("mrst_pc",    inst_pc,         32'h0);
    tick(); tick();

    // L=3 redirect during WAIT -> DROP
    lat = 3;
    rst = 1'b1; #1;
    chk("d0_req",  32'(imem_req), 32'h1);
    chk("d0_addr", imem_addr,     32'h0);
    tick();
    redirect = 1'b1; redirect_addr = 32'h100; #1;
    chk("d1_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0; #1;
    chk("d2_req",   32'(imem_req),   32'h0);
    chk("d2_valid", 32'(inst_valid), 32'h0);
    tick(); #1;
    chk("d3_rv",    32'(imem_rvalid), 32'h1);
    chk("d3_req",   32'(imem_req),    32'h0);
    chk("d3_valid", 32'(inst_valid),  32'h0);
    tick(); #1;
    chk("d4_req",   32'(imem_req),   32'h1);
    chk("d4_addr",  imem_addr,       32'h100);
    chk("d4_valid", 32'(inst_valid), 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("d56_req",   32'(imem_req),   32'h0);
      chk("d56_valid", 32'(inst_valid), 32'h0);
      tick();
    end
    #1;
    chk("d7_valid", 32'(inst_valid), 32'h0);
    chk("d7_req",   32'(imem_req),   32'h1);
    chk("d7_addr",  imem_addr,       32'h104);
    tick();
    stall = 1'b1; #1;
    chk("d8_valid", 32'(inst_valid), 32'h1);
    chk("d8_pc",    inst_pc,         32'h100);
    chk("d8_inst",  inst,            32'hA5A5_0100);
    chk("d8_req",   32'(imem_req),   32'h0);
    tick(); #1;
    chk("d9_req", 32'(imem_req), 32'h0);
    tick();

    // Redirect coincident with rvalid and stall
    redirect = 1'b1; redirect_addr = 32'h200; #1;
    chk("d10_rv",  32'(imem_rvalid), 32'h1);
    chk("d10_req", 32'(imem_req),    32'h0);
    tick();
    redirect = 1'b0; stall = 1'b0; lat = 1; #1;
    chk("d11_valid", 32'(inst_valid), 32'h0);
    chk("d11_inst",  inst,            32'h0);
    chk("d11_pc",    inst_pc,         32'h0);
    chk("d11_req",   32'(imem_req),   32'h1);
    chk("d11_addr",  imem_addr,       32'h200);
    tick();

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFF8; #1;
    chk("d12_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0; #1;
    chk("d13_req",   32'(imem_req),   32'h1);
    chk("d13_addr",  imem_addr,       32'hFFFF_FFF8);
    chk("d13_valid", 32'(inst_valid), 32'h0);
    tick(); #1;
    chk("d14_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("d15_pc",   inst_pc,   32'hFFFF_FFF8);
    chk("d15_addr", imem_addr, 32'h0);
    tick(); #1;
    chk("d16_pc",   inst_pc,   32'hFFFF_FFFC);
    chk("d16_inst", inst,      32'h5A5A_FFFC);
    chk("d16_addr", imem_addr, 32'h4);
    tick(); #1;
    chk("d17_pc",   inst_pc, 32'h0);
    chk("d17_inst", inst,    32'hA5A5_0000);

    // Misaligned redirect
    redirect = 1'b1; redirect_addr = 32'h102; #1;
    chk("d17_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0; #1;
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk("al_err",   32'(addr_err),   32'h1);
      chk("al_req",   32'(imem_req),   32'h0);
      chk("al_valid", 32'(inst_valid), 32'h0);
      tick(); #1;
    end
`else
    chk("al_err",  32'(addr_err), 32'h0);
    chk("al_req",  32'(imem_req), 32'h1);
    chk("al_addr", imem_addr,     32'h100);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
